// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// slave: arbiter side. master: requester/memory side (testbench or surrounding SoC).
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 64
);
    // Processor EX-stage load/store port
    logic              P_En;
    logic              P_WrEn;
    logic [ADDR_W-1:0] P_Addr;
    logic [DATA_W-1:0] P_WrData;
    logic              P_Stall;
    logic [DATA_W-1:0] P_RdData;
    logic              P_RdValid;

    // Requester 1 (network interface / host loader)
    logic              N_Req;
    logic              N_WrEn;
    logic [ADDR_W-1:0] N_Addr;
    logic [DATA_W-1:0] N_WrData;
    logic              N_Gnt;
    logic [DATA_W-1:0] N_RdData;
    logic              N_RdValid;

    // Single-ported memory
    logic              Mem_En;
    logic              Mem_WrEn;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_WrData;
    logic [DATA_W-1:0] Mem_RdData;

    modport slave (
        input  P_En, P_WrEn, P_Addr, P_WrData,
        output P_Stall, P_RdData, P_RdValid,
        input  N_Req, N_WrEn, N_Addr, N_WrData,
        output N_Gnt, N_RdData, N_RdValid,
        output Mem_En, Mem_WrEn, Mem_Addr, Mem_WrData,
        input  Mem_RdData
    );

    modport master (
        output P_En, P_WrEn, P_Addr, P_WrData,
        input  P_Stall, P_RdData, P_RdValid,
        output N_Req, N_WrEn, N_Addr, N_WrData,
        input  N_Gnt, N_RdData, N_RdValid,
        input  Mem_En, Mem_WrEn, Mem_Addr, Mem_WrData,
        output Mem_RdData
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared single-ported data memory.
// Processor port (P_*) and requester 1 (N_*) compete; one wins per cycle, the
// loser stalls, read data is steered back to the owner one cycle later.
// Compile-time option DMEM_ARB_RR_EN: defined -> round-robin on contention;
// undefined -> processor priority with a starvation guard (MAX_WAIT).
module dmem_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned MAX_WAIT = 4
) (
    input logic           Clock,
    input logic           Reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic {OwnerP, OwnerN} owner_e;

    logic   grant_p;
    logic   grant_n;
    logic   n_wins_tie;   // requester 1 takes the memory if both request
    logic   rd_grant;
    logic   rd_pend_q;
    owner_e rd_owner_q;
    logic   p_rd_valid;
    logic   n_rd_valid;

`ifdef DMEM_ARB_RR_EN
    owner_e last_gnt_q;

    // Loser of the previous contention has priority at the next one
    assign n_wins_tie = (last_gnt_q == OwnerP);

    // Round-robin pointer moves only on contention cycles
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_gnt_q <= OwnerN;
        end else if (bus.P_En && bus.N_Req) begin
            last_gnt_q <= grant_n ? OwnerN : OwnerP;
        end
    end
`else
    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic [3:0] wait_q;

    assign n_wins_tie = (wait_q == MaxWait);

    // Count consecutive denied cycles of requester 1, saturating at MaxWait
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wait_q <= '0;
        end else if (!bus.N_Req || grant_n) begin
            wait_q <= '0;
        end else if (wait_q != MaxWait) begin
            wait_q <= wait_q + 4'd1;
        end
    end
`endif

    // Grant decision; nothing is granted while Reset is held
    always_comb begin
        grant_p = !Reset && bus.P_En && !(bus.N_Req && n_wins_tie);
        grant_n = !Reset && bus.N_Req && !grant_p;
    end

    assign bus.P_Stall = !Reset && bus.P_En && !grant_p;
    assign bus.N_Gnt   = grant_n;

    // Winner's request drives the memory; idle bus is all zero
    always_comb begin
        bus.Mem_En     = 1'b0;
        bus.Mem_WrEn   = 1'b0;
        bus.Mem_Addr   = '0;
        bus.Mem_WrData = '0;
        if (grant_p) begin
            bus.Mem_En     = 1'b1;
            bus.Mem_WrEn   = bus.P_WrEn;
            bus.Mem_Addr   = bus.P_Addr;
            bus.Mem_WrData = bus.P_WrData;
        end else if (grant_n) begin
            bus.Mem_En     = 1'b1;
            bus.Mem_WrEn   = bus.N_WrEn;
            bus.Mem_Addr   = bus.N_Addr;
            bus.Mem_WrData = bus.N_WrData;
        end
    end

    assign rd_grant = (grant_p && !bus.P_WrEn) || (grant_n && !bus.N_WrEn);

    // Remember who owns the read data arriving next cycle; reset drops it
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OwnerP;
        end else begin
            rd_pend_q <= rd_grant;
            if (rd_grant) begin
                rd_owner_q <= grant_n ? OwnerN : OwnerP;
            end
        end
    end

    // Steer returning memory data to its owner; the other side sees zero
    always_comb begin
        p_rd_valid    = rd_pend_q && (rd_owner_q == OwnerP);
        n_rd_valid    = rd_pend_q && (rd_owner_q == OwnerN);
        bus.P_RdValid = p_rd_valid;
        bus.N_RdValid = n_rd_valid;
        bus.P_RdData  = p_rd_valid ? bus.Mem_RdData : '0;
        bus.N_RdData  = n_rd_valid ? bus.Mem_RdData : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the arbitration and memory.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned MAX_WAIT = 4;
`ifdef DMEM_ARB_RR_EN
    localparam bit RrBuild = 1'b1;
`else
    localparam bit RrBuild = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 Clock = ~Clock;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    function automatic logic [63:0] init_word(input int a);
        return {32'hC0DE_0000 + 32'(a), 32'(a) * 32'h9E37_79B9};
    endfunction

    // Memory: refilled with a known pattern while Reset is high
    logic [63:0] mem [256];
    logic [63:0] mem_rd_q;
    always @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_rd_q <= '0;
        end else if (bus.Mem_En) begin
            if (bus.Mem_WrEn) mem[bus.Mem_Addr] <= bus.Mem_WrData;
            else              mem_rd_q <= mem[bus.Mem_Addr];
        end
    end
    assign bus.Mem_RdData = mem_rd_q;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.P_En = 0; bus.P_WrEn = 0; bus.P_Addr = '0; bus.P_WrData = '0;
        bus.N_Req = 0; bus.N_WrEn = 0; bus.N_Addr = '0; bus.N_WrData = '0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.P_En = 1; bus.P_WrEn = 1; bus.P_Addr = 8'h12; bus.P_WrData = 64'h55;
        bus.N_Req = 1; bus.N_WrEn = 0; bus.N_Addr = 8'h34; bus.N_WrData = 64'h66;
        #1;
        checks++;
        if ({bus.P_Stall, bus.N_Gnt} !== 2'b00) begin
            errors++; $display("FAIL reset_grants got %b exp 00", {bus.P_Stall, bus.N_Gnt});
        end
        checks++;
        if ({bus.Mem_En, bus.Mem_WrEn, bus.Mem_Addr, bus.Mem_WrData} !== '0) begin
            errors++; $display("FAIL reset_mem_bus got en=%b we=%b a=%h d=%h exp all 0",
                               bus.Mem_En, bus.Mem_WrEn, bus.Mem_Addr, bus.Mem_WrData);
        end
        checks++;
        if ({bus.P_RdValid, bus.N_RdValid, bus.P_RdData, bus.N_RdData} !== '0) begin
            errors++; $display("FAIL reset_rd_return got pv=%b nv=%b pd=%h nd=%h exp all 0",
                               bus.P_RdValid, bus.N_RdValid, bus.P_RdData, bus.N_RdData);
        end
        do_reset();
    endtask

    task automatic test_uncontended();
        do_reset();
        bus.P_En = 1; bus.P_WrEn = 1; bus.P_Addr = 8'h10; bus.P_WrData = 64'hDEAD_BEEF_0000_0001;
        #1;
        checks++;
        if ({bus.Mem_En, bus.Mem_WrEn, bus.P_Stall} !== 3'b110) begin
            errors++; $display("FAIL unc_write_ctl got en/we/stall=%b exp 110",
                               {bus.Mem_En, bus.Mem_WrEn, bus.P_Stall});
        end
        checks++;
        if (bus.Mem_Addr !== 8'h10 || bus.Mem_WrData !== 64'hDEAD_BEEF_0000_0001) begin
            errors++; $display("FAIL unc_write_bus got a=%h d=%h exp 10 deadbeef00000001",
                               bus.Mem_Addr, bus.Mem_WrData);
        end
        @(negedge Clock);
        bus.P_WrEn = 0;
        #1;
        checks++;
        if (bus.P_RdValid !== 1'b0 || bus.Mem_WrEn !== 1'b0) begin
            errors++; $display("FAIL unc_write_no_valid got pv=%b we=%b exp 0 0",
                               bus.P_RdValid, bus.Mem_WrEn);
        end
        @(negedge Clock);
        idle_inputs();
        #1;
        checks++;
        if (bus.P_RdValid !== 1'b1 || bus.P_RdData !== 64'hDEAD_BEEF_0000_0001) begin
            errors++; $display("FAIL unc_read_data got v=%b d=%h exp 1 deadbeef00000001",
                               bus.P_RdValid, bus.P_RdData);
        end
        @(negedge Clock);
        #1;
        checks++;
        if (bus.P_RdValid !== 1'b0) begin
            errors++; $display("FAIL unc_read_pulse got %b exp 0", bus.P_RdValid);
        end
    endtask

    task automatic test_contention();
        bit exp_n;
        bit prev_n;
        do_reset();
        bus.P_En = 1; bus.P_WrEn = 0; bus.P_Addr = 8'h01;
        bus.N_Req = 1; bus.N_WrEn = 0; bus.N_Addr = 8'h02;
        prev_n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_n = RrBuild ? (i % 2 == 1) : (i % (MAX_WAIT + 1) == MAX_WAIT);
            checks++;
            if (bus.N_Gnt !== exp_n || bus.P_Stall !== exp_n) begin
                errors++; $display("FAIL contend_grant cyc%0d got gnt=%b stall=%b exp %b %b",
                                   i, bus.N_Gnt, bus.P_Stall, exp_n, exp_n);
            end
            if (i > 0) begin
                checks++;
                if (bus.N_RdValid !== prev_n || bus.P_RdValid !== !prev_n) begin
                    errors++; $display("FAIL contend_owner cyc%0d got nv=%b pv=%b exp %b %b",
                                       i, bus.N_RdValid, bus.P_RdValid, prev_n, !prev_n);
                end
                checks++;
                if ((prev_n ? bus.N_RdData : bus.P_RdData) !== init_word(prev_n ? 2 : 1)) begin
                    errors++; $display("FAIL contend_data cyc%0d got p=%h n=%h exp %h",
                                       i, bus.P_RdData, bus.N_RdData,
                                       init_word(prev_n ? 2 : 1));
                end
            end
            prev_n = exp_n;
            @(negedge Clock);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        bus.N_Req = 1; bus.N_WrEn = 0; bus.N_Addr = 8'h20;
        #1;
        checks++;
        if (bus.N_Gnt !== 1'b1) begin
            errors++; $display("FAIL rst_mid_gnt got %b exp 1", bus.N_Gnt);
        end
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({bus.N_Gnt, bus.Mem_En, bus.P_Stall} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_forced got gnt/en/stall=%b exp 000",
                               {bus.N_Gnt, bus.Mem_En, bus.P_Stall});
        end
        @(negedge Clock);
        bus.N_Req = 0;
        Reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.N_RdValid !== 1'b0 || bus.N_RdData !== '0) begin
                errors++; $display("FAIL rst_mid_dropped cyc%0d got v=%b d=%h exp 0 0",
                                   i, bus.N_RdValid, bus.N_RdData);
            end
            @(negedge Clock);
        end
        // Return already visible, then reset kills it asynchronously
        bus.N_Req = 1; bus.N_Addr = 8'h21;
        @(negedge Clock);
        bus.N_Req = 0;
        #1;
        checks++;
        if (bus.N_RdValid !== 1'b1 || bus.N_RdData !== init_word(8'h21)) begin
            errors++; $display("FAIL rst_mid_pre got v=%b d=%h exp 1 %h",
                               bus.N_RdValid, bus.N_RdData, init_word(8'h21));
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.N_RdValid !== 1'b0 || bus.N_RdData !== '0) begin
            errors++; $display("FAIL rst_mid_async got v=%b d=%h exp 0 0",
                               bus.N_RdValid, bus.N_RdData);
        end
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checks++;
        if (bus.N_RdValid !== 1'b0 || bus.P_RdValid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_after got nv=%b pv=%b exp 0 0",
                               bus.N_RdValid, bus.P_RdValid);
        end
        @(negedge Clock);
    endtask

    task automatic test_n_write_p_read();
        do_reset();
        bus.N_Req = 1; bus.N_WrEn = 1; bus.N_Addr = 8'hFF; bus.N_WrData = 64'h0123_4567_89AB_CDEF;
        #1;
        checks++;
        if ({bus.N_Gnt, bus.Mem_WrEn, bus.P_Stall} !== 3'b110 || bus.Mem_Addr !== 8'hFF) begin
            errors++; $display("FAIL nwr_grant got gnt/we/stall=%b a=%h exp 110 ff",
                               {bus.N_Gnt, bus.Mem_WrEn, bus.P_Stall}, bus.Mem_Addr);
        end
        @(negedge Clock);
        bus.N_Req = 0;
        bus.P_En = 1; bus.P_WrEn = 0; bus.P_Addr = 8'hFF;
        #1;
        checks++;
        if (bus.N_RdValid !== 1'b0 || bus.P_RdValid !== 1'b0) begin
            errors++; $display("FAIL nwr_no_valid got nv=%b pv=%b exp 0 0",
                               bus.N_RdValid, bus.P_RdValid);
        end
        @(negedge Clock);
        idle_inputs();
        #1;
        checks++;
        if (bus.P_RdValid !== 1'b1 || bus.P_RdData !== 64'h0123_4567_89AB_CDEF ||
            bus.N_RdValid !== 1'b0) begin
            errors++; $display("FAIL nwr_p_read got pv=%b pd=%h nv=%b exp 1 0123456789abcdef 0",
                               bus.P_RdValid, bus.P_RdData, bus.N_RdValid);
        end
        @(negedge Clock);
    endtask

    task automatic test_wren_without_en();
        idle_inputs();
        bus.P_WrEn = 1; bus.P_Addr = 8'h05; bus.P_WrData = 64'hFFFF_0000_FFFF_0000;
        bus.N_WrEn = 1; bus.N_Addr = 8'h06; bus.N_WrData = 64'h1111;
        #1;
        checks++;
        if ({bus.Mem_En, bus.Mem_WrEn, bus.P_Stall, bus.N_Gnt} !== 4'b0000 ||
            bus.Mem_Addr !== '0) begin
            errors++; $display("FAIL wren_only got en/we/stall/gnt=%b a=%h exp 0000 00",
                               {bus.Mem_En, bus.Mem_WrEn, bus.P_Stall, bus.N_Gnt}, bus.Mem_Addr);
        end
        @(negedge Clock);
        idle_inputs();
        bus.P_En = 1; bus.P_Addr = 8'h05;
        @(negedge Clock);
        idle_inputs();
        #1;
        checks++;
        if (bus.P_RdData !== init_word(5)) begin
            errors++; $display("FAIL wren_only_mem got %h exp %h", bus.P_RdData, init_word(5));
        end
        @(negedge Clock);
    endtask

    task automatic test_same_address();
        do_reset();
        bus.P_En = 1; bus.P_WrEn = 1; bus.P_Addr = 8'h33; bus.P_WrData = 64'hA5A5_5A5A_0F0F_F0F0;
        @(negedge Clock);
        bus.P_WrEn = 0;
        bus.N_Req = 1; bus.N_WrEn = 0; bus.N_Addr = 8'h33;
        #1;
        checks++;
        if (bus.P_Stall !== 1'b0 || bus.N_Gnt !== 1'b0) begin
            errors++; $display("FAIL same_first got stall=%b gnt=%b exp 0 0",
                               bus.P_Stall, bus.N_Gnt);
        end
        @(negedge Clock);
        bus.P_En = 0;
        #1;
        checks++;
        if (bus.N_Gnt !== 1'b1 || bus.P_RdValid !== 1'b1 ||
            bus.P_RdData !== 64'hA5A5_5A5A_0F0F_F0F0) begin
            errors++; $display("FAIL same_p got gnt=%b pv=%b pd=%h exp 1 1 a5a55a5a0f0ff0f0",
                               bus.N_Gnt, bus.P_RdValid, bus.P_RdData);
        end
        @(negedge Clock);
        idle_inputs();
        #1;
        checks++;
        if (bus.N_RdValid !== 1'b1 || bus.N_RdData !== 64'hA5A5_5A5A_0F0F_F0F0 ||
            bus.P_RdValid !== 1'b0) begin
            errors++; $display("FAIL same_n got nv=%b nd=%h pv=%b exp 1 a5a55a5a0f0ff0f0 0",
                               bus.N_RdValid, bus.N_RdData, bus.P_RdValid);
        end
        @(negedge Clock);
    endtask

    // Randomized traffic; requesters hold a request until it is granted
    task automatic test_random();
        logic [63:0] model_mem [256];
        bit          m_prio_n;       // round-robin: requester 1 wins next tie
        int          m_streak;       // fixed: consecutive denied cycles of requester 1
        bit          m_pend;
        bit          m_pend_n;
        logic [63:0] m_pend_data;
        bit          pr, pw, nr, nw, gp, gn, p_hold, n_hold;
        logic [7:0]  pa, na;
        logic [63:0] pd, nd;
        bit          e_en, e_we;
        logic [7:0]  e_a;
        logic [63:0] e_d;

        do_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
        m_prio_n = 0; m_streak = 0; m_pend = 0; m_pend_n = 0; m_pend_data = '0;
        p_hold = 0; n_hold = 0;
        pr = 0; pw = 0; pa = '0; pd = '0; nr = 0; nw = 0; na = '0; nd = '0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!p_hold) begin
                pr = ($urandom_range(0, 3) != 0);
                pw = $urandom_range(0, 1) == 1;
                pa = 8'($urandom_range(0, 15));
                pd = {$urandom, $urandom};
            end
            if (!n_hold) begin
                nr = ($urandom_range(0, 1) == 1);
                nw = $urandom_range(0, 1) == 1;
                na = 8'($urandom_range(0, 15));
                nd = {$urandom, $urandom};
            end
            bus.P_En = pr; bus.P_WrEn = pw; bus.P_Addr = pa; bus.P_WrData = pd;
            bus.N_Req = nr; bus.N_WrEn = nw; bus.N_Addr = na; bus.N_WrData = nd;
            #1;

            if (pr && nr) gn = RrBuild ? m_prio_n : (m_streak >= int'(MAX_WAIT));
            else          gn = nr;
            gp = pr && !gn;
            e_en = gp || gn;
            e_we = gp ? pw : (gn ? nw : 1'b0);
            e_a  = gp ? pa : (gn ? na : 8'h00);
            e_d  = gp ? pd : (gn ? nd : 64'h0);

            checks++;
            if (bus.P_Stall !== (pr && !gp) || bus.N_Gnt !== gn) begin
                errors++; $display("FAIL rand_grant cyc%0d got stall=%b gnt=%b exp %b %b",
                                   cyc, bus.P_Stall, bus.N_Gnt, pr && !gp, gn);
            end
            checks++;
            if (bus.Mem_En !== e_en || bus.Mem_WrEn !== e_we || bus.Mem_Addr !== e_a ||
                bus.Mem_WrData !== e_d) begin
                errors++; $display("FAIL rand_mem cyc%0d got %b %b %h %h exp %b %b %h %h", cyc,
                                   bus.Mem_En, bus.Mem_WrEn, bus.Mem_Addr, bus.Mem_WrData,
                                   e_en, e_we, e_a, e_d);
            end
            checks++;
            if (bus.P_RdValid !== (m_pend && !m_pend_n) || bus.N_RdValid !== (m_pend && m_pend_n))
            begin
                errors++; $display("FAIL rand_valid cyc%0d got pv=%b nv=%b exp %b %b", cyc,
                                   bus.P_RdValid, bus.N_RdValid,
                                   m_pend && !m_pend_n, m_pend && m_pend_n);
            end
            checks++;
            if (bus.P_RdData !== ((m_pend && !m_pend_n) ? m_pend_data : 64'h0) ||
                bus.N_RdData !== ((m_pend && m_pend_n) ? m_pend_data : 64'h0)) begin
                errors++; $display("FAIL rand_data cyc%0d got p=%h n=%h exp owner_n=%b %h", cyc,
                                   bus.P_RdData, bus.N_RdData, m_pend_n, m_pend && m_pend_data);
            end

            p_hold = pr && !gp;
            n_hold = nr && !gn;
            @(posedge Clock);
            m_pend = e_en && !e_we;
            if (e_en && e_we) model_mem[e_a] = e_d;
            if (m_pend) begin
                m_pend_n    = gn;
                m_pend_data = model_mem[e_a];
            end
            if (pr && nr) m_prio_n = gp;
            if (nr && !gn) m_streak = (m_streak < int'(MAX_WAIT)) ? m_streak + 1 : int'(MAX_WAIT);
            else           m_streak = 0;
            @(negedge Clock);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_uncontended();
        test_contention();
        test_reset_mid_read();
        test_n_write_p_read();
        test_wren_without_en();
        test_same_address();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported 256 x 64-bit data memory between the cardinal processor's EX-stage load/store port and a second requester (network-interface / host loader). It picks one request per cycle, drives the memory, routes read data back to the owner one cycle later and stalls the loser. Grant fairness is round-robin or fixed-priority with a starvation guard, selected at compile time.

## Interface
- ADDR_W, 8, memory word address width
- DATA_W, 64, data width
- MAX_WAIT, 4, fixed-priority mode only: consecutive lost cycles after which requester 1 is forced to win (1..15)

- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high
- P_En  in  1  processor memory access request (DmemEn)
- P_WrEn  in  1  processor write qualifier (DmemWrEn)
- P_Addr  in  ADDR_W  processor word address
- P_WrData  in  DATA_W  processor store data
- P_Stall  out  1  processor request not granted this cycle; processor holds pipeline and request
- P_RdData  out  DATA_W  read data returned to processor
- P_RdValid  out  1  P_RdData valid (one cycle after granted read)
- N_Req  in  1  requester 1 access request; held until granted
- N_WrEn  in  1  requester 1 write qualifier
- N_Addr  in  ADDR_W  requester 1 word address
- N_WrData  in  DATA_W  requester 1 write data
- N_Gnt  out  1  requester 1 granted this cycle
- N_RdData  out  DATA_W  read data returned to requester 1
- N_RdValid  out  1  N_RdData valid
- Mem_En  out  1  memory enable
- Mem_WrEn  out  1  memory write enable
- Mem_Addr  out  ADDR_W  memory address
- Mem_WrData  out  DATA_W  memory write data
- Mem_RdData  in  DATA_W  memory read data, valid the cycle after a read enable

## Operation
- Grant is combinational from current requests plus registered state (priority pointer, wait counter); the winner's En/WrEn/Addr/WrData are muxed onto Mem_*. No request: Mem_En=0, Mem_WrEn=0, Mem_Addr=0, Mem_WrData=0.
- P_Stall = P_En & ~grant_P. N_Gnt = N_Req & grant_N. Exactly one grant when both request; never a grant without a request.
- Read return: on a granted read, registered tag rd_owner (P/N) and rd_pend set; next cycle Mem_RdData is copied combinationally to the owner's RdData and its RdValid pulses for one cycle. Non-owner RdData holds 0. Writes produce no RdValid.
- Round-robin pointer last_gnt: updated only on a contention cycle (both requesting); the loser has priority next contention.
- Wait counter (fixed-priority mode): increments when N_Req is denied, clears on N_Gnt or ~N_Req; saturates at MAX_WAIT.
- Reset mid-operation: all registers clear asynchronously; any in-flight read return is dropped (no RdValid after reset deasserts).
- Requests with En=0 and WrEn=1 are ignored (WrEn only qualifies En).

## Timing
- Reset values: P_Stall=0, N_Gnt=0, P_RdValid=0, N_RdValid=0, P_RdData=0, N_RdData=0, Mem_En=0, Mem_WrEn=0, Mem_Addr=0, Mem_WrData=0; last_gnt=N (processor wins first contention); wait counter=0; rd_pend=0. Grants forced 0 while Reset=1.
- Uncontended access: zero added latency; write commits at edge of grant cycle; read data valid cycle N+1.
- Contended: loser stalls 1 cycle minimum; back-to-back reads by alternating owners return in grant order, one per cycle.
- Simultaneous processor and requester-1 reads to the same address: both serviced, in consecutive cycles.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin via last_gnt; wait counter not instantiated; MAX_WAIT ignored.
- Not defined: processor wins every contention, except when wait counter == MAX_WAIT, in which case requester 1 wins that cycle and the counter clears. last_gnt not instantiated.

## Test plan
- Reset then P_En=1, P_WrEn=1, P_Addr=8'h10, P_WrData=64'hDEAD_BEEF_0000_0001, N_Req=0 -> Mem_En=1, Mem_WrEn=1, P_Stall=0; following read of 8'h10 -> P_RdValid=1 next cycle, P_RdData=64'hDEAD_BEEF_0000_0001.
- RR build: both request reads (P_Addr=8'h01, N_Addr=8'h02) for 4 cycles -> grants P,N,P,N; P_Stall=0,1,0,1; RdValid owner alternates one cycle later.
- Fixed build, MAX_WAIT=4: both request continuously -> processor granted 4 cycles, N_Gnt=1 on 5th, then pattern repeats (4:1).
- N read granted at cycle 0, Reset asserted in cycle 1 before edge -> N_RdValid stays 0 through and after reset; all outputs at reset values.
- N_Req only, write 8'hFF with 64'h0123_4567_89AB_CDEF, then P read 8'hFF -> N_Gnt=1, no RdValid for write; P_RdData=64'h0123_4567_89AB_CDEF, N_RdValid=0.
- P_En=0, P_WrEn=1, N_Req=0 -> Mem_En=0, Mem_WrEn=0, no stall, no grant.
